corr_pkt_fifo: RTL and testbench



---
 rtl/corr_pkt_pkg.sv | 21 ++
 rtl/corr_pkt_fifo_byte_fifo_mem.sv | 79 +++++++
 rtl/corr_pkt_fifo.sv | 155 +++++++++++++++
 tb/tb_corr_pkt_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : corr_pkt_pkg
// Description : Shared types and constants for the correlator packet FIFO.
//               Contains the serialiser state encoding, the sequence-number
//               width, the drop-counter width and the empty-read data value.
// Revision    : 1.0  initial release
// ============================================================================
package corr_pkt_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int         SEQNUM_W   = 8;
  localparam int         DROP_CNT_W = 8;
  localparam logic [7:0] EMPTY_DATA = 8'h00;

endpackage
`default_nettype wire

// File: rtl/corr_pkt_fifo_byte_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo_mem
// Description : DEPTH x 8 circular byte buffer. Registered write, combinational
//               head read, wrapping pointers and a separate occupancy counter.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               cg              - clock gate; state advances only when high
//               push, push_data - write one byte at the write pointer
//               pop             - consume head byte (ignored when empty)
//               head_data       - head byte, EMPTY_DATA when empty
//               empty           - occupancy == 0
//               occupancy       - bytes held (0..DEPTH)
// Revision    : 1.0  initial release
// ============================================================================
module byte_fifo_mem
  import corr_pkt_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cg,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          do_push;
  logic          do_pop;

  // The producer never pushes without room (checked at packet accept), so the
  // push is not qualified by fullness.
  assign do_push = push && cg;
  assign do_pop  = pop && (occ != '0) && cg;

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign empty     = (occ == '0);
  assign head_data = empty ? EMPTY_DATA : mem[rd_ptr];
  assign occupancy = occ;

endmodule
`default_nettype wire

// File: rtl/corr_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : corr_pkt_fifo
// Description : Packetising byte FIFO. Accepts a whole correlator packet only
//               if the buffer has room for all of it, then serialises it MSB
//               byte first, one byte per gated cycle, into a circular buffer
//               whose head is read through an empty/pop interface.
// Ports       : i_clk, i_rst     - clock, synchronous active-high reset
//               i_cg             - clock gate; all state frozen when low
//               i_pkt_data/valid - packet offer; o_pkt_ready high in IDLE
//               o_pktfifo_data   - head byte (0x00 when empty)
//               o_pktfifo_empty  - buffer empty
//               i_pktfifo_pop    - consume head byte
//               o_occupancy      - bytes held
//               o_nDropped       - saturating count of rejected packets
// Options     : CORR_PKT_FIFO_SEQNUM_EN - prepend an 8-bit sequence number
//               byte to every accepted packet (packet length PKT_BYTES+1).
// Revision    : 1.0  initial release
// ============================================================================
module corr_pkt_fifo
  import corr_pkt_pkg::*;
#(
  parameter int PKT_BYTES = 4,
  parameter int DEPTH     = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [8*PKT_BYTES-1:0] i_pkt_data,
  input  logic                   i_pkt_valid,
  output logic                   o_pkt_ready,
  output logic [7:0]             o_pktfifo_data,
  output logic                   o_pktfifo_empty,
  input  logic                   i_pktfifo_pop,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic [DROP_CNT_W-1:0]  o_nDropped
);

`ifdef CORR_PKT_FIFO_SEQNUM_EN
  localparam int PKT_LEN = PKT_BYTES + 1;
`else
  localparam int PKT_LEN = PKT_BYTES;
`endif
  localparam int SR_W  = 8 * PKT_LEN;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(PKT_LEN + 1);

  localparam logic [OCC_W-1:0] DEPTH_OCC   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] PKT_LEN_OCC = OCC_W'(PKT_LEN);
  localparam logic [CNT_W-1:0] PKT_LEN_CNT = CNT_W'(PKT_LEN);

  state_t                state_q, state_d;
  logic [SR_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;
  logic [SR_W-1:0]       load_word;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W-1:0]      free_space;
  logic                  has_room;
  logic                  offer;
  logic                  push;
  logic [7:0]            push_data;

`ifdef CORR_PKT_FIFO_SEQNUM_EN
  logic [SEQNUM_W-1:0]   seq_q, seq_d;
  assign load_word = {seq_q, i_pkt_data};
`else
  assign load_word = i_pkt_data;
`endif

  // Room is judged once at accept time; pops during WRITE only add space.
  assign free_space = DEPTH_OCC - occupancy;
  assign has_room   = (free_space >= PKT_LEN_OCC);
  assign offer      = (state_q == IDLE) && i_pkt_valid && i_cg;
  assign push_data  = shift_q[SR_W-1 -: 8];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      dropped_q <= '0;
`ifdef CORR_PKT_FIFO_SEQNUM_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
`ifdef CORR_PKT_FIFO_SEQNUM_EN
      seq_q     <= seq_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    dropped_d = dropped_q;
    push      = 1'b0;
`ifdef CORR_PKT_FIFO_SEQNUM_EN
    seq_d     = seq_q;
`endif
    case (state_q)
      IDLE: begin
        if (offer) begin
          if (has_room) begin
            shift_d = load_word;
            cnt_d   = PKT_LEN_CNT;
            state_d = WRITE;
`ifdef CORR_PKT_FIFO_SEQNUM_EN
            seq_d   = seq_q + SEQNUM_W'(1);
`endif
          end else if (dropped_q != '1) begin
            dropped_d = dropped_q + DROP_CNT_W'(1);
          end
        end
      end
      WRITE: begin
        // The buffer applies i_cg to the push itself.
        push = 1'b1;
        if (i_cg) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  byte_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (i_clk),
    .rst       (i_rst),
    .cg        (i_cg),
    .push      (push),
    .push_data (push_data),
    .pop       (i_pktfifo_pop),
    .head_data (o_pktfifo_data),
    .empty     (o_pktfifo_empty),
    .occupancy (occupancy)
  );

  assign o_pkt_ready = (state_q == IDLE);
  assign o_occupancy = occupancy;
  assign o_nDropped  = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_corr_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_corr_pkt_fifo
// Description : Self-checking bench for corr_pkt_fifo. Stimulus pushes the
//               expected byte stream of each accepted packet into a queue; a
//               monitor compares every byte the DUT hands out on a pop.
// Revision    : 1.0  initial release
// ============================================================================
module tb_corr_pkt_fifo;

  localparam int PB    = 4;
  localparam int DEPTH = 64;
`ifdef CORR_PKT_FIFO_SEQNUM_EN
  localparam int L = PB + 1;
`else
  localparam int L = PB;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cg = 1'b1;
  logic [8*PB-1:0]        pkt_data = '0;
  logic                   pkt_valid = 1'b0;
  logic                   pkt_ready;
  logic [7:0]             ff_data;
  logic                   ff_empty;
  logic                   ff_pop = 1'b0;
  logic [$clog2(DEPTH):0] occ;
  logic [7:0]             n_dropped;

  int       n_checks = 0;
  int       n_fail   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_seq = 8'h00;

  corr_pkt_fifo #(
    .PKT_BYTES (PB),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cg            (cg),
    .i_pkt_data      (pkt_data),
    .i_pkt_valid     (pkt_valid),
    .o_pkt_ready     (pkt_ready),
    .o_pktfifo_data  (ff_data),
    .o_pktfifo_empty (ff_empty),
    .i_pktfifo_pop   (ff_pop),
    .o_occupancy     (occ),
    .o_nDropped      (n_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*PB-1:0] pkt_of(input int i);
    logic [8*PB-1:0] v;
    for (int k = 0; k < PB; k++) v[8*k +: 8] = 8'(i * 8 + k);
    return v;
  endfunction

  // Offer one packet; if it is expected to be accepted, queue its bytes in
  // transmission order. Returns one tick after the handshake edge.
  task automatic send_pkt(input logic [8*PB-1:0] d, input bit accept);
    int guard = 0;
    while (!pkt_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!pkt_ready) check("ready_timeout", 32'(pkt_ready), 32'd1);
    pkt_data  = d;
    pkt_valid = 1'b1;
    if (accept) begin
`ifdef CORR_PKT_FIFO_SEQNUM_EN
      exp_q.push_back(exp_seq);
      exp_seq = exp_seq + 8'd1;
`endif
      for (int k = PB - 1; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
    end
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    ff_pop = 1'b1;
    while (!ff_empty && guard < 200) begin
      tick();
      guard++;
    end
    ff_pop = 1'b0;
    if (!ff_empty) check("drain_timeout", 32'(ff_empty), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_seq = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: sampled mid-cycle; a pop seen here is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && cg && ff_pop && !ff_empty) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(ff_data), 32'hFFFF_FFFF);
      end else begin
        check("head_byte", 32'(ff_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_fill;
    int fill_occ;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_empty", 32'(ff_empty), 32'd1);
    check("rst_data", 32'(ff_data), 32'h00);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_dropped", 32'(n_dropped), 32'd0);
    check("rst_ready", 32'(pkt_ready), 32'd1);

    // Single packet: ready low for L cycles, then read back in order
    send_pkt(32'hAABBCCDD, 1'b1);
    for (int i = 0; i < L; i++) begin
      check("write_ready_low", 32'(pkt_ready), 32'd0);
      tick();
    end
    check("write_ready_back", 32'(pkt_ready), 32'd1);
    check("one_pkt_occ", 32'(occ), 32'(L));
    drain();
    check("one_pkt_empty", 32'(ff_empty), 32'd1);
    check("one_pkt_occ_end", 32'(occ), 32'd0);
    check("one_pkt_data0", 32'(ff_data), 32'h00);

    // Clock gate low: offer must not be taken, nothing moves
    cg        = 1'b0;
    pkt_data  = 32'h11223344;
    pkt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cg_ready", 32'(pkt_ready), 32'd1);
      check("cg_occ", 32'(occ), 32'd0);
    end
    pkt_valid = 1'b0;
    cg        = 1'b1;
    tick();
    check("cg_no_pkt", 32'(occ), 32'd0);

    // Fill to 62 (or as near as whole packets allow), then a dropped offer
    n_fill = DEPTH / L;
    for (int i = 0; i < n_fill; i++) send_pkt(pkt_of(i + 1), 1'b1);
    repeat (L) tick();
    fill_occ = n_fill * L;
    check("fill_occ", 32'(occ), 32'(fill_occ));
    if (fill_occ > DEPTH - 2) begin
      ff_pop = 1'b1;
      repeat (fill_occ - (DEPTH - 2)) tick();
      ff_pop = 1'b0;
      fill_occ = DEPTH - 2;
    end
    check("pre_drop_occ", 32'(occ), 32'(fill_occ));
    send_pkt(pkt_of(50), 1'b0);
    check("drop_count", 32'(n_dropped), 32'd1);
    check("drop_occ", 32'(occ), 32'(fill_occ));
    check("drop_ready", 32'(pkt_ready), 32'd1);
    tick();
    check("drop_occ_hold", 32'(occ), 32'(fill_occ));
    drain();
    // The next accepted packet also shows the drop did not consume a seqnum
    send_pkt(pkt_of(51), 1'b1);
    repeat (L) tick();
    drain();

    // Continuous pop during WRITE: occupancy stays at 1, no empty glitch
    ff_pop = 1'b1;
    send_pkt(32'h5A6B7C8D, 1'b1);
    tick();
    for (int i = 0; i < L; i++) begin
      check("stream_empty", 32'(ff_empty), 32'd0);
      check("stream_occ_le1", 32'(occ <= 1), 32'd1);
      tick();
    end
    check("stream_done_empty", 32'(ff_empty), 32'd1);
    check("stream_done_occ", 32'(occ), 32'd0);

    // Twenty packets with popping: pointers wrap through 63 -> 0
    for (int i = 0; i < 20; i++) send_pkt(pkt_of(100 + i), 1'b1);
    repeat (L) tick();
    drain();
    check("wrap_occ", 32'(occ), 32'd0);
    check("wrap_queue_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of WRITE after two bytes
    send_pkt(32'hDEADBEEF, 1'b1);
    tick();
    tick();
    check("pre_rst_occ", 32'(occ), 32'd2);
    do_reset();
    check("midrst_empty", 32'(ff_empty), 32'd1);
    check("midrst_data", 32'(ff_data), 32'h00);
    check("midrst_occ", 32'(occ), 32'd0);
    check("midrst_ready", 32'(pkt_ready), 32'd1);
    check("midrst_dropped", 32'(n_dropped), 32'd0);
    send_pkt(32'h01234567, 1'b1);
    repeat (L) tick();
    check("post_rst_occ", 32'(occ), 32'(L));
    drain();

`ifdef CORR_PKT_FIFO_SEQNUM_EN
    // Sequence numbers restart at zero and step per accepted packet
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(pkt_of(200 + i), 1'b1);
    repeat (L) tick();
    check("seq_occ", 32'(occ), 32'(3 * L));
    drain();
`endif

    check("final_queue_left", 32'(exp_q.size()), 32'd0);
    check("final_empty", 32'(ff_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
